// File: rtl/sport_ram_arbiter.sv
// rtl/sport_ram_arbiter.sv - two-requester arbiter in front of a registered single-port RAM
//
// Purpose: accepts read/write requests from two requesters (r0, r1), runs one
// transaction at a time against SPort_RAM through ram_addr/ram_wenable/ram_din
// and ram_dout, and returns a one-cycle completion pulse to the owner.
// Transaction flow: IDLE -> ISSUE -> (CAPT, reads only) -> RESP -> IDLE.
// Latency from handshake edge to rsp_valid: write 2 cycles, read 3 cycles.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   rn_valid/rn_ready             request handshake (n = 0, 1)
//   rn_we/rn_addr/rn_wdata        request payload
//   rn_rsp_valid/rn_rsp_rdata     completion pulse and held read data
//   ram_addr/ram_wenable/ram_din  to SPort_RAM
//   ram_dout                      from SPort_RAM (registered, updates on non-write edges)
//
// Configuration:
//   SPORT_RAM_ARB_FIXED_PRIO_EN   defined: r0 always wins a tie (no pointer)
//                                 undefined: round-robin on the last-served requester
module sport_ram_arbiter #(
   parameter int AW = 3,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          r0_valid,
   output logic          r0_ready,
   input  logic          r0_we,
   input  logic [AW-1:0] r0_addr,
   input  logic [DW-1:0] r0_wdata,
   output logic          r0_rsp_valid,
   output logic [DW-1:0] r0_rsp_rdata,
   input  logic          r1_valid,
   output logic          r1_ready,
   input  logic          r1_we,
   input  logic [AW-1:0] r1_addr,
   input  logic [DW-1:0] r1_wdata,
   output logic          r1_rsp_valid,
   output logic [DW-1:0] r1_rsp_rdata,
   output logic [AW-1:0] ram_addr,
   output logic          ram_wenable,
   output logic [DW-1:0] ram_din,
   input  logic [DW-1:0] ram_dout
);

   typedef enum logic [1:0] {IDLE, ISSUE, CAPT, RESP} state_t;

   state_t state, state_nxt;
   logic   owner;      // 0 = r0 owns the in-flight transaction, 1 = r1
   logic   grant1;     // arbitration winner in IDLE: 1 = r1, 0 = r0
   logic   hs;         // handshake with the winner this cycle

`ifdef SPORT_RAM_ARB_FIXED_PRIO_EN
   always_comb begin
      grant1 = r1_valid && !r0_valid;
   end
`else
   logic last;         // 1 = r1 was served last, so r0 wins the next tie

   always_comb begin
      grant1 = r1_valid && (!r0_valid || !last);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         last <= 1'b1;
      else if (hs)
         last <= grant1;
   end
`endif

   assign hs = (state == IDLE) && (r0_valid || r1_valid);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (hs) state_nxt = ISSUE;
         ISSUE:   state_nxt = ram_wenable ? RESP : CAPT;
         CAPT:    state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output logic; gated by rst so nothing is offered or acknowledged in reset
   always_comb begin
      r0_ready     = !rst && (state == IDLE) && r0_valid && !grant1;
      r1_ready     = !rst && (state == IDLE) && grant1;
      r0_rsp_valid = !rst && (state == RESP) && !owner;
      r1_rsp_valid = !rst && (state == RESP) && owner;
   end

   // Datapath: request capture, RAM drive and read-data capture
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner        <= 1'b0;
         ram_addr     <= '0;
         ram_wenable  <= 1'b0;
         ram_din      <= '0;
         r0_rsp_rdata <= '0;
         r1_rsp_rdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (hs) begin
                  owner       <= grant1;
                  ram_addr    <= grant1 ? r1_addr  : r0_addr;
                  ram_wenable <= grant1 ? r1_we    : r0_we;
                  ram_din     <= grant1 ? r1_wdata : r0_wdata;
               end
            end
            // The write strobe lives for the ISSUE cycle only; address stays
            // put so the RAM's registered read output remains valid in CAPT.
            ISSUE: ram_wenable <= 1'b0;
            CAPT: begin
               if (owner)
                  r1_rsp_rdata <= ram_dout;
               else
                  r0_rsp_rdata <= ram_dout;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sport_ram_arbiter.sv
// tb/tb_sport_ram_arbiter.sv - directed self-checking bench for sport_ram_arbiter
module tb_sport_ram_arbiter;

   localparam int AW = 3;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          r0_valid, r0_ready, r0_we, r0_rsp_valid;
   logic [AW-1:0] r0_addr;
   logic [DW-1:0] r0_wdata, r0_rsp_rdata;
   logic          r1_valid, r1_ready, r1_we, r1_rsp_valid;
   logic [AW-1:0] r1_addr;
   logic [DW-1:0] r1_wdata, r1_rsp_rdata;
   logic [AW-1:0] ram_addr;
   logic          ram_wenable;
   logic [DW-1:0] ram_din, ram_dout;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   sport_ram_arbiter #(.AW(AW), .DW(DW)) dut (
      .clk(clk), .rst(rst),
      .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_we(r0_we), .r0_addr(r0_addr),
      .r0_wdata(r0_wdata), .r0_rsp_valid(r0_rsp_valid), .r0_rsp_rdata(r0_rsp_rdata),
      .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_we(r1_we), .r1_addr(r1_addr),
      .r1_wdata(r1_wdata), .r1_rsp_valid(r1_rsp_valid), .r1_rsp_rdata(r1_rsp_rdata),
      .ram_addr(ram_addr), .ram_wenable(ram_wenable), .ram_din(ram_din), .ram_dout(ram_dout)
   );

   // SPort_RAM model: write on wenable edges, registered read on the others
   logic [DW-1:0] mem [0:(1<<AW)-1];
   initial begin
      for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h100 + i;
      mem[1] = 32'd78;
      mem[2] = 32'h0000_2222;
      ram_dout = '0;
   end
   always @(posedge clk) begin
      if (ram_wenable) mem[ram_addr] <= ram_din;
      else             ram_dout <= mem[ram_addr];
   end

   task automatic set_req(input int n, input logic v, input logic we,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
      if (n == 0) begin r0_valid = v; r0_we = we; r0_addr = a; r0_wdata = d; end
      else        begin r1_valid = v; r1_we = we; r1_addr = a; r1_wdata = d; end
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // Runs one transaction for requester n and measures it. lat is the number of
   // negedges after the handshake edge until rsp_valid is seen (-1 on timeout).
   task automatic run_txn(input int n, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, output int lat,
                          output logic [DW-1:0] rdata, output int wen, output int other);
      logic rdy;
      lat = -1; rdata = '0; wen = 0; other = 0;
      set_req(n, 1'b1, we, a, d);
      rdy = 1'b0;
      for (int i = 0; i < 20 && !rdy; i++) begin
         @(negedge clk);
         rdy = (n == 0) ? r0_ready : r1_ready;
      end
      if (!rdy) begin
         set_req(n, 1'b0, 1'b0, '0, '0);
         return;
      end
      @(posedge clk); #1;
      set_req(n, 1'b0, ~we, ~a, ~d);   // inputs must be ignored after acceptance
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (ram_wenable) wen++;
         if ((n == 0) ? r1_rsp_valid : r0_rsp_valid) other++;
         if ((n == 0) ? r0_rsp_valid : r1_rsp_valid) begin
            lat = k;
            rdata = (n == 0) ? r0_rsp_rdata : r1_rsp_rdata;
            break;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_req(0, 1'b1, 1'b0, 3'd1, '0);
      set_req(1, 1'b1, 1'b0, 3'd2, '0);
      #1;
      checks++; if (r0_ready !== 1'b0 || r1_ready !== 1'b0) begin errors++;
         $display("FAIL reset_ready: got r0=%b r1=%b expected 0 0", r0_ready, r1_ready); end
      checks++; if (r0_rsp_valid !== 1'b0 || r1_rsp_valid !== 1'b0) begin errors++;
         $display("FAIL reset_rsp_valid: got r0=%b r1=%b expected 0 0", r0_rsp_valid, r1_rsp_valid); end
      checks++; if (ram_addr !== 3'd0 || ram_wenable !== 1'b0 || ram_din !== 32'd0) begin errors++;
         $display("FAIL reset_ram: got addr=%0d we=%b din=%h expected 0 0 0", ram_addr, ram_wenable, ram_din); end
      checks++; if (r0_rsp_rdata !== 32'd0 || r1_rsp_rdata !== 32'd0) begin errors++;
         $display("FAIL reset_rdata: got %h %h expected 0 0", r0_rsp_rdata, r1_rsp_rdata); end
      set_req(0, 1'b0, 1'b0, '0, '0);
      set_req(1, 1'b0, 1'b0, '0, '0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_single_read();
      int lat, wen, other; logic [DW-1:0] rd;
      run_txn(0, 1'b0, 3'd1, '0, lat, rd, wen, other);
      checks++; if (lat !== 3) begin errors++;
         $display("FAIL single_read_latency: got %0d expected 3", lat); end
      checks++; if (rd !== 32'd78) begin errors++;
         $display("FAIL single_read_data: got %0d expected 78", rd); end
      checks++; if (other !== 0 || wen !== 0) begin errors++;
         $display("FAIL single_read_side: got r1_rsp=%0d wen=%0d expected 0 0", other, wen); end
   endtask

   task automatic test_write_read();
      int lat, wen, other; logic [DW-1:0] rd;
      run_txn(1, 1'b1, 3'd5, 32'hDEADBEEF, lat, rd, wen, other);
      checks++; if (lat !== 2) begin errors++;
         $display("FAIL write_latency: got %0d expected 2", lat); end
      checks++; if (wen !== 1) begin errors++;
         $display("FAIL write_wenable_cycles: got %0d expected 1", wen); end
      checks++; if (other !== 0) begin errors++;
         $display("FAIL write_other_rsp: got %0d expected 0", other); end
      run_txn(1, 1'b0, 3'd5, '0, lat, rd, wen, other);
      checks++; if (lat !== 3) begin errors++;
         $display("FAIL wr_read_latency: got %0d expected 3", lat); end
      checks++; if (rd !== 32'hDEADBEEF) begin errors++;
         $display("FAIL wr_read_data: got %h expected deadbeef", rd); end
      checks++; if (r0_rsp_rdata !== 32'd78) begin errors++;
         $display("FAIL rdata_hold: got r0_rsp_rdata=%0d expected 78", r0_rsp_rdata); end
   endtask

   task automatic test_contention();
      int seq [8];
      int exp_seq [8];
      int cnt0, cnt1, ng, both;
      pulse_reset();
`ifdef SPORT_RAM_ARB_FIXED_PRIO_EN
      exp_seq = '{0, 0, 0, 0, 1, 1, 1, 1};
`else
      exp_seq = '{0, 1, 0, 1, 0, 1, 0, 1};
`endif
      cnt0 = 0; cnt1 = 0; ng = 0; both = 0;
      for (int i = 0; i < 8; i++) seq[i] = -1;
      set_req(0, 1'b1, 1'b0, 3'd1, '0);
      set_req(1, 1'b1, 1'b0, 3'd2, '0);
      for (int c = 0; c < 200 && ng < 8; c++) begin
         @(negedge clk);
         if (r0_ready && r1_ready) both++;
         if (r0_ready) begin seq[ng] = 0; ng++; cnt0++; end
         else if (r1_ready) begin seq[ng] = 1; ng++; cnt1++; end
         @(posedge clk); #1;
         if (cnt0 >= 4) r0_valid = 1'b0;
         if (cnt1 >= 4) r1_valid = 1'b0;
      end
      r0_valid = 1'b0; r1_valid = 1'b0;
      repeat (4) @(posedge clk); #1;
      checks++; if (both !== 0) begin errors++;
         $display("FAIL contention_both_ready: got %0d cycles expected 0", both); end
      for (int i = 0; i < 8; i++) begin
         checks++; if (seq[i] !== exp_seq[i]) begin errors++;
            $display("FAIL contention_grant[%0d]: got r%0d expected r%0d", i, seq[i], exp_seq[i]); end
      end
      checks++; if (r0_rsp_rdata !== 32'd78 || r1_rsp_rdata !== 32'h2222) begin errors++;
         $display("FAIL contention_rdata: got %h %h expected 0000004e 00002222", r0_rsp_rdata, r1_rsp_rdata); end
   endtask

   task automatic test_reset_mid_read();
      int lat, wen, other, seen; logic [DW-1:0] rd; logic rdy;
      set_req(0, 1'b1, 1'b0, 3'd2, '0);
      rdy = 1'b0;
      for (int i = 0; i < 20 && !rdy; i++) begin @(negedge clk); rdy = r0_ready; end
      @(posedge clk); #1;            // handshake edge passed: ISSUE
      set_req(0, 1'b0, 1'b0, '0, '0);
      @(posedge clk); #1;            // now in CAPT
      rst = 1'b1;
      r0_valid = 1'b1;
      #1;
      checks++; if (r0_ready !== 1'b0 || r0_rsp_valid !== 1'b0 || r1_rsp_valid !== 1'b0) begin errors++;
         $display("FAIL midrst_handshake: got ready=%b rsp0=%b rsp1=%b expected 0 0 0", r0_ready, r0_rsp_valid, r1_rsp_valid); end
      checks++; if (ram_addr !== 3'd0 || ram_wenable !== 1'b0 || ram_din !== 32'd0 ||
                    r0_rsp_rdata !== 32'd0 || r1_rsp_rdata !== 32'd0) begin errors++;
         $display("FAIL midrst_outputs: got addr=%0d we=%b din=%h rd0=%h rd1=%h expected all 0",
                  ram_addr, ram_wenable, ram_din, r0_rsp_rdata, r1_rsp_rdata); end
      r0_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      seen = 0;
      repeat (5) begin @(negedge clk); if (r0_rsp_valid || r1_rsp_valid) seen++; end
      @(posedge clk); #1;
      checks++; if (seen !== 0) begin errors++;
         $display("FAIL midrst_no_rsp: got %0d pulses expected 0", seen); end
      run_txn(1, 1'b0, 3'd2, '0, lat, rd, wen, other);
      checks++; if (lat !== 3 || rd !== 32'h2222) begin errors++;
         $display("FAIL midrst_next_read: got lat=%0d data=%h expected 3 00002222", lat, rd); end
   endtask

   task automatic test_ordering();
      int got0, got1; logic [DW-1:0] rd1; logic rdy;
      pulse_reset();
      set_req(0, 1'b1, 1'b1, 3'd0, 32'd7);
      set_req(1, 1'b1, 1'b0, 3'd0, '0);
      @(negedge clk);
      checks++; if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin errors++;
         $display("FAIL order_first_grant: got r0=%b r1=%b expected 1 0", r0_ready, r1_ready); end
      @(posedge clk); #1;
      r0_valid = 1'b0;
      got0 = 0; got1 = 0; rd1 = '0; rdy = 1'b0;
      for (int c = 0; c < 30 && got1 == 0; c++) begin
         @(negedge clk);
         if (r0_rsp_valid) got0++;
         if (r1_rsp_valid) begin got1++; rd1 = r1_rsp_rdata; end
         if (r1_ready) rdy = 1'b1;
         @(posedge clk); #1;
         if (rdy) r1_valid = 1'b0;
      end
      r1_valid = 1'b0;
      checks++; if (got0 !== 1) begin errors++;
         $display("FAIL order_write_ack: got %0d expected 1", got0); end
      checks++; if (got1 !== 1 || rd1 !== 32'd7) begin errors++;
         $display("FAIL order_read_data: got pulses=%0d data=%0d expected 1 7", got1, rd1); end
   endtask

   initial begin
      rst = 1'b1;
      set_req(0, 1'b0, 1'b0, '0, '0);
      set_req(1, 1'b0, 1'b0, '0, '0);
      test_reset();
      test_single_read();
      test_write_read();
      test_contention();
      test_reset_mid_read();
      test_ordering();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
